// File: rtl/keypad_pkg.sv
// Keypad scanner shared definitions: FSM state encoding, keymap and row priority helpers.
// Pure combinational helpers; no latency, no flow control.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } scan_state_t;

  function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] hex;
    case ({row, col})
      4'h0: hex = 4'h1;
      4'h1: hex = 4'h2;
      4'h2: hex = 4'h3;
      4'h3: hex = 4'hA;
      4'h4: hex = 4'h4;
      4'h5: hex = 4'h5;
      4'h6: hex = 4'h6;
      4'h7: hex = 4'hB;
      4'h8: hex = 4'h7;
      4'h9: hex = 4'h8;
      4'hA: hex = 4'h9;
      4'hB: hex = 4'hC;
      4'hC: hex = 4'hE;
      4'hD: hex = 4'h0;
      4'hE: hex = 4'hF;
      default: hex = 4'hD;
    endcase
    return hex;
  endfunction

  // Rows are active-low; the lowest index wins when several are pulled low.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] row_bits);
    logic [1:0] idx;
    if (!row_bits[0])      idx = 2'd0;
    else if (!row_bits[1]) idx = 2'd1;
    else if (!row_bits[2]) idx = 2'd2;
    else                   idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, resetting to all-ones (idle pulled-up lines).
// Latency: 2 clk cycles; no backpressure.
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_fsm.sv
// 4x4 keypad column scanner with press/release debounce; emits one registered strobe per key press.
// Latency: strobe 1 cycle after DEBOUNCE_CNT stable cycles (+2 sync); no backpressure, strobe is fire-and-forget.
module keypad_scan_fsm #(
  parameter int SCAN_DIV     = 24000,
  parameter int DEBOUNCE_CNT = 480000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic       new_hex,
  output logic [3:0] hex_R_new
);
  import keypad_pkg::*;

  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int DW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CNT - 1);

  logic [3:0]    rows_s;
  scan_state_t   state, state_nxt;
  logic [1:0]    col, col_nxt;
  logic [1:0]    key_row, key_row_nxt;
  logic [SW-1:0] scan_cnt, scan_cnt_nxt;
  logic [DW-1:0] deb_cnt, deb_cnt_nxt;
  logic          new_hex_nxt;
  logic [3:0]    hex_nxt;
  logic          key_low;

  sync_2ff #(.W(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rows),
    .q     (rows_s)
  );

  assign key_low = ~rows_s[key_row];
  assign cols    = ~(4'b0001 << col);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SCAN;
      col       <= 2'd0;
      key_row   <= 2'd0;
      scan_cnt  <= '0;
      deb_cnt   <= '0;
      new_hex   <= 1'b0;
      hex_R_new <= 4'h0;
    end else begin
      state     <= state_nxt;
      col       <= col_nxt;
      key_row   <= key_row_nxt;
      scan_cnt  <= scan_cnt_nxt;
      deb_cnt   <= deb_cnt_nxt;
      new_hex   <= new_hex_nxt;
      hex_R_new <= hex_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    col_nxt      = col;
    key_row_nxt  = key_row;
    scan_cnt_nxt = scan_cnt;
    deb_cnt_nxt  = deb_cnt;
    new_hex_nxt  = 1'b0;
    hex_nxt      = hex_R_new;
    case (state)
      SCAN: begin
        if (scan_cnt == SCAN_LAST) begin
          scan_cnt_nxt = '0;
          if (rows_s != 4'hF) begin
            state_nxt   = DEBOUNCE;
            key_row_nxt = lowest_low_row(rows_s);
            deb_cnt_nxt = '0;
          end else begin
            col_nxt = col + 2'd1;
          end
        end else begin
          scan_cnt_nxt = scan_cnt + SW'(1);
        end
      end
      DEBOUNCE: begin
        if (!key_low) begin
          state_nxt    = SCAN;
          col_nxt      = col + 2'd1;
          scan_cnt_nxt = '0;
          deb_cnt_nxt  = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt   = HELD;
          new_hex_nxt = 1'b1;
          hex_nxt     = keymap(key_row, col);
          deb_cnt_nxt = '0;
        end else begin
          deb_cnt_nxt = deb_cnt + DW'(1);
        end
      end
      HELD: begin
        if (!key_low) begin
          state_nxt   = RELEASE;
          deb_cnt_nxt = '0;
        end
      end
      RELEASE: begin
        // A key that reappears before release qualifies goes back to HELD without a new strobe.
        if (key_low) begin
          state_nxt   = HELD;
          deb_cnt_nxt = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt    = SCAN;
          col_nxt      = col + 2'd1;
          scan_cnt_nxt = '0;
          deb_cnt_nxt  = '0;
        end else begin
          deb_cnt_nxt = deb_cnt + DW'(1);
        end
      end
      default: begin
        state_nxt    = SCAN;
        scan_cnt_nxt = '0;
        deb_cnt_nxt  = '0;
      end
    endcase
  end

endmodule

// File: doc/keypad_scan_fsm.md
KEYPAD_SCAN_FSM -- requirements
Module: keypad_scan_fsm

Interface
REQ-001 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-002 SCAN_DIV, 24000, clk cycles each column is driven during scanning (minimum 4).
REQ-003 DEBOUNCE_CNT, 480000, consecutive stable clk cycles that qualify a press or a release (minimum 2).
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low (0 = reset).
REQ-006 rows  input  4  keypad row lines, active-low (pulled up), asynchronous to clk.
REQ-007 cols  output  4  column drive, active-low one-hot; exactly one bit low at all times.
REQ-008 new_hex  output  1  one-cycle strobe: a debounced key press is qualified.
REQ-009 hex_R_new  output  4  hex code of the last qualified key; valid when new_hex=1 and held until the next strobe.

Function
REQ-010 rows SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized value rows_s.
REQ-011 States SHALL be SCAN, DEBOUNCE, HELD, RELEASE.
REQ-012 SCAN: drive column c (0..3, wrapping 3->0) for SCAN_DIV cycles; sample rows_s only on the last dwell cycle; if all rows are high, advance to c+1 on the next cycle.
REQ-013 SCAN, sample with any row low: latch c and the lowest-index low row r, hold the column, and enter DEBOUNCE with the counter cleared.
REQ-014 DEBOUNCE: count cycles while rows_s[r]=0; when the count reaches DEBOUNCE_CNT, pulse new_hex for exactly 1 cycle, update hex_R_new in the same cycle, and enter HELD.
REQ-015 DEBOUNCE: if rows_s[r]=1 on any cycle, return to SCAN at column c+1 with no strobe.
REQ-016 HELD: keep column c driven; stay while rows_s[r]=0; on rows_s[r]=1 enter RELEASE with the counter cleared.
REQ-017 RELEASE: count cycles while rows_s[r]=1; at DEBOUNCE_CNT, return to SCAN at column c+1; if rows_s[r]=0 first, return to HELD with no strobe.
REQ-018 Keymap (row r, column c), r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: E 0 F D.
REQ-019 Any other key pressed while a key is in DEBOUNCE, HELD or RELEASE SHALL be ignored; one physical press SHALL produce exactly one strobe.
REQ-020 Multiple low rows in one sampled column SHALL resolve to the lowest row index.
REQ-021 Counters SHALL be $clog2(param+1) bits wide, saturate-free, and be cleared on every state change.
REQ-022 new_hex SHALL never be high on two consecutive cycles.

Reset
REQ-023 When reset=0, the block SHALL go to SCAN at column 0: cols=4'b1110, new_hex=0, hex_R_new=4'h0, counters=0, synchronizer flops=4'b1111.
REQ-024 Reset asserted mid-DEBOUNCE or mid-HELD SHALL abandon the key with no strobe; after release, a key still held SHALL be rescanned and qualified once.

Structure
REQ-025 Package keypad_pkg SHALL hold the state enum typedef and the keymap lookup function (row, col -> 4-bit hex).
REQ-026 Sub-module sync_2ff (4-bit, active-low async reset, reset value 1s) SHALL implement REQ-010.
REQ-027 Outputs new_hex and hex_R_new SHALL be registered so that they drive the digit-storage block directly.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8)
REQ-028 Press r1,c2 held 40 cycles, then release -> exactly one new_hex strobe with hex_R_new=4'h6; cols returns to scanning.
REQ-029 Press r3,c0 with 3-cycle bounces (low 3, high 2, then stable low) -> no strobe during bounces, single strobe with hex_R_new=4'hE after 8 stable cycles.
REQ-030 Hold r0,c3 (4'hA), then add r2,c1 -> one strobe A only; after both are released, pressing r2,c1 gives hex_R_new=4'h8.
REQ-031 Release glitch on HELD key (high 3 cycles, then low) -> no second strobe; cols stays on the held column.
REQ-032 Press r0 and r2 together in c1 -> hex_R_new=4'h2; idle sweep shows cols 1110,1101,1011,0111,1110 at 4-cycle spacing.
REQ-033 reset=0 during DEBOUNCE of r1,c1 -> cols=1110 and new_hex=0 immediately; key still held after reset -> one strobe, 4'h5.
